// File: rtl/sccb_target_model.sv
// SCCB target emulating the OV7670 register interface: 256x8 register file,
// 3-phase writes, 2-phase sub-address writes and 2-phase reads on open-drain SDA.
module sccb_target_model #(
    parameter logic [7:0]  DEV_ID   = 8'h42,
    parameter int unsigned HOLD_CYC = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic       wr_stb,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_DEV  = 3'd1;
    localparam logic [2:0] ST_SUB  = 3'd2;
    localparam logic [2:0] ST_WR   = 3'd3;
    localparam logic [2:0] ST_RD   = 3'd4;
    localparam logic [2:0] ST_IGN  = 3'd5;

    localparam logic [7:0] RD_ID     = DEV_ID | 8'h01;
    localparam logic [3:0] HOLD_INIT = 4'(HOLD_CYC);

    function automatic logic [7:0] reg_default(input logic [7:0] a);
        case (a)
            8'h0A:   reg_default = 8'h76;
            8'h0B:   reg_default = 8'h73;
            8'h1C:   reg_default = 8'h7F;
            8'h1D:   reg_default = 8'hA2;
            default: reg_default = 8'h00;
        endcase
    endfunction

    function automatic logic is_read_only(input logic [7:0] a);
        return (a == 8'h0A) || (a == 8'h0B) || (a == 8'h1C) || (a == 8'h1D);
    endfunction

    function automatic logic [255:0][7:0] reg_defaults();
        logic [255:0][7:0] v;
        for (int i = 0; i < 256; i++) begin
            v[i] = reg_default(8'(i));
        end
        return v;
    endfunction

    logic             scl_p0, scl_p1, scl_p2;
    logic             sda_p0, sda_p1, sda_p2;
    logic             scl_rise, scl_fall, bus_start, bus_stop, bus_event, ack_rise;
    logic [2:0]       state;
    logic [3:0]       bit_cnt;
    logic [3:0]       hold_cnt;
    logic [7:0]       shift_q;
    logic [7:0]       ptr;
    logic [7:0]       rd_byte;
    logic             oe_pend;
    logic             oe_next;
    logic             wr_en;
    logic             soft_rst;
    logic [7:0]       wr_val;
    logic [255:0][7:0] regs_q;
    logic [255:0][7:0] regs_d;

    // Stage p0/p1: synchronizers; p2 holds the previous level for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_p0 <= 1'b1;
            scl_p1 <= 1'b1;
            scl_p2 <= 1'b1;
            sda_p0 <= 1'b1;
            sda_p1 <= 1'b1;
            sda_p2 <= 1'b1;
        end else begin
            scl_p0 <= scl_i;
            scl_p1 <= scl_p0;
            scl_p2 <= scl_p1;
            sda_p0 <= sda_i;
            sda_p1 <= sda_p0;
            sda_p2 <= sda_p1;
        end
    end

    assign scl_rise  = scl_p1 & ~scl_p2;
    assign scl_fall  = ~scl_p1 & scl_p2;
    assign bus_start = scl_p1 & scl_p2 & sda_p2 & ~sda_p1;
    assign bus_stop  = scl_p1 & scl_p2 & ~sda_p2 & sda_p1;
    assign bus_event = bus_start | bus_stop;

    // The ACK-bit rising edge is where every completed byte takes effect.
    assign ack_rise = scl_rise && (bit_cnt == 4'd8) && !bus_event && (state != ST_IDLE);
    assign wr_en    = ack_rise && (state == ST_WR) && !is_read_only(ptr);
    assign soft_rst = wr_en && (ptr == 8'h12) && shift_q[7];
    assign wr_val   = soft_rst ? {1'b0, shift_q[6:0]} : shift_q;

    always_comb begin
        oe_next = 1'b0;
        if (bit_cnt == 4'd8) begin
            case (state)
                ST_DEV:       oe_next = (shift_q == DEV_ID) || (shift_q == RD_ID);
                ST_SUB, ST_WR: oe_next = 1'b1;
                default:      oe_next = 1'b0;
            endcase
        end else if (state == ST_RD) begin
            oe_next = ~rd_byte[3'd7 - bit_cnt[2:0]];
        end
    end

    always_comb begin
        regs_d = regs_q;
        if (soft_rst) begin
            regs_d = reg_defaults();
        end
        if (wr_en) begin
            regs_d[ptr] = wr_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= reg_defaults();
        end else begin
            regs_q <= regs_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            bit_cnt  <= 4'd0;
            hold_cnt <= 4'd0;
            shift_q  <= 8'h00;
            ptr      <= 8'h00;
            rd_byte  <= 8'h00;
            oe_pend  <= 1'b0;
            sda_oe   <= 1'b0;
            wr_stb   <= 1'b0;
            wr_addr  <= 8'h00;
            wr_data  <= 8'h00;
            busy     <= 1'b0;
        end else begin
            wr_stb <= 1'b0;
            if (bus_event) begin
                // START/STOP abandon any partial byte and pending SDA change.
                sda_oe   <= 1'b0;
                hold_cnt <= 4'd0;
                bit_cnt  <= 4'd0;
                state    <= bus_start ? ST_DEV : ST_IDLE;
                busy     <= bus_start;
            end else if (state != ST_IDLE) begin
                if (hold_cnt != 4'd0) begin
                    hold_cnt <= hold_cnt - 4'd1;
                    if (hold_cnt == 4'd1) begin
                        sda_oe <= oe_pend;
                    end
                end
                if (scl_fall) begin
                    hold_cnt <= HOLD_INIT;
                    oe_pend  <= oe_next;
                end
                if (scl_rise && (bit_cnt != 4'd8)) begin
                    shift_q <= {shift_q[6:0], sda_p1};
                    bit_cnt <= bit_cnt + 4'd1;
                end
                if (ack_rise) begin
                    bit_cnt <= 4'd0;
                    case (state)
                        ST_DEV: begin
                            if (shift_q == DEV_ID) begin
                                state <= ST_SUB;
                            end else if (shift_q == RD_ID) begin
                                rd_byte <= regs_q[ptr];
                                state   <= ST_RD;
                            end else begin
                                state <= ST_IGN;
                            end
                        end
                        ST_SUB: begin
                            ptr   <= shift_q;
                            state <= ST_WR;
                        end
                        ST_WR: begin
                            if (wr_en) begin
                                wr_stb  <= 1'b1;
                                wr_addr <= ptr;
                                wr_data <= shift_q;
                            end
                            ptr <= ptr + 8'd1;
                        end
                        ST_RD: begin
                            if (!sda_p1) begin
                                ptr     <= ptr + 8'd1;
                                rd_byte <= regs_q[ptr + 8'd1];
                            end else begin
                                state <= ST_IGN;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_sccb_target_model.sv
// Bench for sccb_target_model: a bit-banged SCCB master on a wired-AND bus,
// checked against a register-level model of the OV7670 target.
module tb_sccb_target_model;

    localparam int Q = 8;

    logic       clk;
    logic       rst;
    logic       scl_i;
    logic       sda_i;
    logic       sda_oe;
    logic       wr_stb;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       scl_m;
    logic       sda_m_low;

    assign scl_i = scl_m;
    assign sda_i = ~(sda_m_low | sda_oe);

    sccb_target_model #(.DEV_ID(8'h42), .HOLD_CYC(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .scl_i  (scl_i),
        .sda_i  (sda_i),
        .sda_oe (sda_oe),
        .wr_stb (wr_stb),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  m_regs [256];
    logic [7:0]  m_ptr;
    logic [15:0] exp_stb [$];
    logic [15:0] obs_stb [$];
    logic [7:0]  wbuf [$];

    always @(negedge clk) begin
        if (wr_stb) obs_stb.push_back({wr_addr, wr_data});
    end

    initial begin
        #950000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model of the register file as a camera datasheet describes it.
    function automatic logic [7:0] def_val(input int a);
        if (a == 'h0A) return 8'h76;
        if (a == 'h0B) return 8'h73;
        if (a == 'h1C) return 8'h7F;
        if (a == 'h1D) return 8'hA2;
        return 8'h00;
    endfunction

    task automatic model_reset_regs();
        for (int i = 0; i < 256; i++) m_regs[i] = def_val(i);
    endtask

    task automatic model_write(input logic [7:0] d);
        if (!(m_ptr inside {8'h0A, 8'h0B, 8'h1C, 8'h1D})) begin
            exp_stb.push_back({m_ptr, d});
            if (m_ptr == 8'h12 && d[7]) begin
                model_reset_regs();
                m_regs[8'h12] = d & 8'h7F;
            end else begin
                m_regs[m_ptr] = d;
            end
        end
        m_ptr = m_ptr + 8'd1;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_start();
        sda_m_low = 1'b0; tick(Q);
        scl_m = 1'b1;     tick(Q);
        sda_m_low = 1'b1; tick(Q);
        scl_m = 1'b0;     tick(Q);
    endtask

    task automatic bus_stop();
        sda_m_low = 1'b1; tick(Q);
        scl_m = 1'b1;     tick(Q);
        sda_m_low = 1'b0; tick(Q);
    endtask

    task automatic send_bit(input logic b);
        sda_m_low = ~b; tick(Q);
        scl_m = 1'b1;   tick(2 * Q);
        scl_m = 1'b0;   tick(Q);
    endtask

    task automatic recv_bit(output logic b);
        sda_m_low = 1'b0; tick(Q);
        scl_m = 1'b1;     tick(Q);
        @(negedge clk);
        b = sda_i;
        tick(Q);
        scl_m = 1'b0;     tick(Q);
    endtask

    task automatic send_byte(input logic [7:0] v, output logic ack, output logic oe);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
        sda_m_low = 1'b0; tick(Q);
        scl_m = 1'b1;     tick(Q);
        @(negedge clk);
        ack = sda_i;
        oe  = sda_oe;
        tick(Q);
        scl_m = 1'b0;     tick(Q);
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] v);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            v[i] = b;
        end
        send_bit(nack);
    endtask

    task automatic expect_ack(input string tag, input logic [7:0] v);
        logic a, o;
        send_byte(v, a, o);
        check({tag, " ack"}, 32'(a), 32'(0));
        check({tag, " oe"}, 32'(o), 32'(1));
    endtask

    task automatic compare_stb(input string tag);
        int n;
        check({tag, " stb count"}, 32'(obs_stb.size()), 32'(exp_stb.size()));
        n = (obs_stb.size() < exp_stb.size()) ? obs_stb.size() : exp_stb.size();
        for (int i = 0; i < n; i++) check({tag, " stb addr/data"}, 32'(obs_stb[i]), 32'(exp_stb[i]));
        obs_stb.delete();
        exp_stb.delete();
    endtask

    task automatic end_txn(input string tag);
        bus_stop();
        tick(4);
        @(negedge clk);
        check({tag, " busy after P"}, 32'(busy), 32'(0));
        compare_stb(tag);
    endtask

    task automatic write_txn(input logic [7:0] sub, input string tag);
        bus_start();
        expect_ack({tag, " dev"}, 8'h42);
        check({tag, " busy"}, 32'(busy), 32'(1));
        expect_ack({tag, " sub"}, sub);
        m_ptr = sub;
        foreach (wbuf[i]) begin
            expect_ack({tag, " data"}, wbuf[i]);
            model_write(wbuf[i]);
        end
        end_txn(tag);
    endtask

    task automatic read_txn(input logic [7:0] sub, input int n, input string tag);
        logic [7:0] b;
        wbuf.delete();
        write_txn(sub, tag);
        bus_start();
        expect_ack({tag, " rdev"}, 8'h43);
        for (int k = 0; k < n; k++) begin
            recv_byte(k == n - 1, b);
            check({tag, " rd data"}, 32'(b), 32'(m_regs[m_ptr]));
            if (k != n - 1) m_ptr = m_ptr + 8'd1;
        end
        end_txn(tag);
    endtask

    task automatic pulse_rst(input string tag);
        @(negedge clk);
        check({tag, " busy before rst"}, 32'(busy), 32'(1));
        rst = 1'b1;
        tick(1);
        @(negedge clk);
        check({tag, " oe after rst"}, 32'(sda_oe), 32'(0));
        check({tag, " busy after rst"}, 32'(busy), 32'(0));
        rst = 1'b0;
        model_reset_regs();
        m_ptr = 8'h00;
    endtask

    initial begin
        logic       a, o, b;
        logic [7:0] sub;
        logic [7:0] trunc;
        int         n;

        rst = 1'b1;
        scl_m = 1'b1;
        sda_m_low = 1'b0;
        model_reset_regs();
        m_ptr = 8'h00;
        tick(3);
        @(negedge clk);
        check("reset sda_oe", 32'(sda_oe), 32'(0));
        check("reset wr_stb", 32'(wr_stb), 32'(0));
        check("reset wr_addr", 32'(wr_addr), 32'(0));
        check("reset wr_data", 32'(wr_data), 32'(0));
        check("reset busy", 32'(busy), 32'(0));
        rst = 1'b0;
        tick(2 * Q);

        // 3-phase write, 2-phase sub-address write, then read back.
        wbuf = '{8'h04};
        write_txn(8'h3A, "wr3A");
        read_txn(8'h3A, 1, "rd3A");

        // ID registers with a master ACK then NACK.
        read_txn(8'h0A, 2, "rdID");

        // Wrong device address is never acknowledged.
        bus_start();
        send_byte(8'h60, a, o);
        check("bad dev ack", 32'(a), 32'(1));
        check("bad dev oe", 32'(o), 32'(0));
        send_byte(8'h3A, a, o);
        check("ignored byte ack", 32'(a), 32'(1));
        end_txn("bad dev");

        // Burst write wrapping the pointer past FF.
        wbuf = '{8'h11, 8'h22, 8'h33};
        write_txn(8'hFE, "burst");
        read_txn(8'hFE, 3, "burst rd");

        // Read-only register write is acknowledged but has no effect.
        wbuf = '{8'h5A};
        write_txn(8'h1C, "ro wr");
        read_txn(8'h1C, 1, "ro rd");

        // COM7 soft reset.
        wbuf = '{8'h55};
        write_txn(8'h12, "com7 55");
        wbuf = '{8'h80};
        write_txn(8'h12, "com7 80");
        read_txn(8'h12, 1, "com7 rd");
        read_txn(8'h3A, 1, "com7 3A");
        read_txn(8'hFE, 3, "com7 burst");

        // Repeated START after 5 data bits discards the partial byte.
        bus_start();
        expect_ack("trunc dev", 8'h42);
        expect_ack("trunc sub", 8'h10);
        trunc = 8'hC3;
        for (int i = 7; i >= 3; i--) send_bit(trunc[i]);
        wbuf = '{8'h9A};
        write_txn(8'h10, "after Sr");
        read_txn(8'h10, 1, "rd10");

        // Reset in the middle of a write data byte.
        bus_start();
        expect_ack("rstw dev", 8'h42);
        expect_ack("rstw sub", 8'h3B);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        pulse_rst("rstw");
        end_txn("rstw");

        // Reset while the target drives a read bit; pointer restarts at 0.
        bus_start();
        expect_ack("rstr dev", 8'h43);
        for (int i = 7; i >= 5; i--) begin
            recv_bit(b);
            check("rstr bit", 32'(b), 32'(m_regs[0][i]));
        end
        tick(2);
        @(negedge clk);
        check("rstr driving", 32'(sda_oe), 32'(1));
        pulse_rst("rstr");
        end_txn("rstr");
        read_txn(8'h10, 1, "post rst 10");
        read_txn(8'h0A, 2, "post rst ID");

        // Random writes and reads against the model.
        for (int t = 0; t < 16; t++) begin
            sub = 8'($urandom_range(0, 255));
            n = $urandom_range(1, 3);
            if ($urandom_range(0, 1) == 1) begin
                wbuf.delete();
                for (int k = 0; k < n; k++) wbuf.push_back(8'($urandom));
                write_txn(sub, "rand wr");
            end else begin
                read_txn(sub, n, "rand rd");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sccb_target_model.md
Name: sccb_target_model

Overview:
- SCCB/I2C target (responder) that emulates the OV7670 register interface. It is the opposite end of the camera SCCB master.
- Holds a 256x8 register file. It accepts 3-phase writes, 2-phase sub-address writes and 2-phase reads, and drives SDA open-drain.
- Used as a synthesizable camera stand-in for board-level loopback and as the bus target in master verification.
- Also exports a write strobe, so system logic can observe each register update.

Parameters:
- DEV_ID, 8'h42, write device address; the read address is DEV_ID|1 (8'h43).
- HOLD_CYC, 4, clk cycles between a detected SCL falling edge and any change of sda_oe (SDA hold time). Range 1..15.

Ports:
- clk  in  1  system clock; at least 8x the SCL frequency.
- rst  in  1  synchronous, active-high reset.
- scl_i  in  1  raw SCL pin level.
- sda_i  in  1  raw SDA pin level.
- sda_oe  out  1  1 = pull SDA low, 0 = release. The top level builds the tristate.
- wr_stb  out  1  one-cycle pulse per register byte written.
- wr_addr  out  8  sub-address of the write; valid while wr_stb=1.
- wr_data  out  8  data of the write; valid while wr_stb=1.
- busy  out  1  high from START until STOP or abort.

Behaviour:
- Reset values:
  - Outputs: sda_oe=0, wr_stb=0, wr_addr=0, wr_data=0, busy=0. State=IDLE.
  - Register file: all 8'h00 except 0x0A=76, 0x0B=73, 0x1C=7F, 0x1D=A2. These four are read-only; writes to them are ACKed but ignored and do not pulse wr_stb.
- Input conditioning and bus events:
  - scl_i and sda_i each pass through 2-FF synchronizers; edges are detected on the synchronized values.
  - START/repeated START = SDA falls while SCL high. STOP = SDA rises while SCL high.
  - START/STOP are recognized in every state, take priority over bit processing, and release sda_oe in the same cycle.
- Bit timing:
  - Bits are sampled on the synchronized SCL rising edge, MSB first.
  - sda_oe changes only HOLD_CYC cycles after a synchronized SCL falling edge.
- States:
  - IDLE: wait for START; then go to DEV and set busy=1.
  - DEV: shift 8 bits.
    - Byte = DEV_ID: ACK, then go to SUB.
    - Byte = DEV_ID|1: latch the read byte from reg[ptr], ACK, then go to RD.
    - Otherwise: no ACK, go to IGNORE.
  - SUB: shift 8 bits, ptr <= byte, ACK, then go to WR.
  - WR: shift 8 bits and ACK. On the SCL rising edge that samples the ACK bit:
    - write reg[ptr];
    - pulse wr_stb with wr_addr=ptr and wr_data=byte;
    - ptr <= ptr+1 (8-bit wrap: FF -> 00).
    - Stay in WR for burst writes.
  - RD: drive the latched byte; for each bit, sda_oe = ~bit. Release during the 9th bit and sample the master's ACK.
    - ACK (0): ptr <= ptr+1, latch the next byte, stay in RD.
    - NACK (1): go to IGNORE.
  - IGNORE: sda_oe=0; wait for START (go to DEV) or STOP (go to IDLE).
- ACK drive: sda_oe=1 from HOLD_CYC after the 8th SCL fall until HOLD_CYC after the 9th SCL fall.
- COM7 soft reset: a write to 0x12 with bit7=1 restores all register defaults. reg[0x12] then holds the data value with bit7 cleared. wr_stb still pulses with the original data.
- ptr persistence: ptr survives STOP, so a 2-phase write (START 42 sub STOP) followed by a read (START 43) returns reg[sub].
- Partial bytes: a STOP or START mid-byte discards that byte with no register write and no strobe.
- Reset mid-transfer: the block returns to IDLE in the next cycle and sda_oe=0 immediately. ptr resets to 0.

Test Plan:
- Write 42 / 3A / 04 with P, then write 42 / 3A, P, then read 43 with master NACK, P -> ACK on all 3 write bytes; wr_stb once with wr_addr=3A, wr_data=04; read byte 04 on SDA; busy low after each P.
- Read ID: write 42 / 0A, P, then 43 with master ACK, then master NACK -> bytes 76 then 73; wr_stb never pulses.
- Wrong address 60 -> no ACK on the 9th bit (sda_oe=0); no strobe; state IDLE after P.
- Burst write 42 / FE / 11 / 22 / 33 -> registers FE=11, FF=22, 00=33; three wr_stb pulses with wr_addr FE, FF, 00.
- Write 12=55, then write 12=80, then read 12 -> reads 00; the earlier write to 3A has returned to 00.
- Repeated START after 5 bits of the data byte, then a new 42 / 10 / 9A / P, and a reset pulse applied mid-data-byte -> the truncated byte is not written; reg[10]=9A is written; after reset, sda_oe=0 and busy=0 within 1 cycle.
